ahbl_master: RTL

Single-port AHB-Lite initiator (bus master) converting a simple valid/ready command stream into pipelined AHB-Lite SINGLE transfers, returning one response per command. Sits between a CPU/DMA-style requester and the AHB-Lite fabric, driving the slaves on that bus, such as the on-chip memory. Supports back-to-back overlapped address/data phases, slave wait states and, optionally, two-cycle ERROR responses.

---
 rtl/ahbl_pkg.sv | 31 +++
 rtl/ahbl_master.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, the error-handling FSM state type and a
// command-size to HSIZE helper for the ahbl_master initiator.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic {
        ST_OK,
        ST_ERR_CANCEL
    } err_state_e;

    // Encoding 3 is not a legal 32-bit-bus request, so it is folded onto word.
    function automatic logic [2:0] cmd_size_to_hsize(input logic [1:0] size);
        logic [2:0] hsize;
        case (size)
            2'd0:    hsize = HSIZE_BYTE;
            2'd1:    hsize = HSIZE_HALF;
            default: hsize = HSIZE_WORD;
        endcase
        return hsize;
    endfunction

endpackage

// File: rtl/ahbl_master.sv
// AHB-Lite single-transfer initiator: valid/ready command in, pipelined NONSEQ
// transfers out, one response per command. Define AHBL_MASTER_ERROR_EN for ERROR handling.
module ahbl_master
    import ahbl_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA
);

    logic        ap_valid_q, ap_valid_d;
    logic [31:0] ap_addr_q,  ap_addr_d;
    logic        ap_write_q, ap_write_d;
    logic [2:0]  ap_size_q,  ap_size_d;
    logic [31:0] ap_wdata_q, ap_wdata_d;

    logic        dp_valid_q, dp_valid_d;
    logic        dp_write_q, dp_write_d;
    logic [31:0] hwdata_q,   hwdata_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q,   rsp_err_d;

    logic        advance;
    logic        resp_err_in;

`ifdef AHBL_MASTER_ERROR_EN
    err_state_e state_q, state_d;
    logic       err_seen;

    assign err_seen    = (state_q == ST_ERR_CANCEL);
    assign resp_err_in = HRESP;

    // OK -> ERR_CANCEL on the first (HREADY low) ERROR cycle; back on the closing edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OK:         if (dp_valid_q && HRESP && !HREADY) state_d = ST_ERR_CANCEL;
            ST_ERR_CANCEL: if (HREADY) state_d = ST_OK;
            default:       state_d = ST_OK;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_OK;
        end else begin
            state_q <= state_d;
        end
    end
`else
    localparam logic err_seen = 1'b0;
    logic unused_hresp;

    assign unused_hresp = HRESP;
    assign resp_err_in  = 1'b0;
`endif

    assign advance   = HREADY & ~err_seen;
    assign cmd_ready = advance;

    always_comb begin
        ap_valid_d  = ap_valid_q;
        ap_addr_d   = ap_addr_q;
        ap_write_d  = ap_write_q;
        ap_size_d   = ap_size_q;
        ap_wdata_d  = ap_wdata_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (advance) begin
            dp_valid_d = ap_valid_q;
            dp_write_d = ap_write_q;
            if (ap_valid_q && ap_write_q) begin
                hwdata_d = ap_wdata_q;
            end
            if (cmd_valid) begin
                ap_valid_d = 1'b1;
                ap_addr_d  = cmd_addr;
                ap_write_d = cmd_write;
                ap_size_d  = cmd_size_to_hsize(cmd_size);
                ap_wdata_d = cmd_wdata;
            end else begin
                ap_valid_d = 1'b0;
            end
        end else if (HREADY) begin
            // Closing edge of an ERROR: the errored transfer retires while the
            // cancelled address phase stays put to be re-driven next cycle.
            dp_valid_d = 1'b0;
        end

        if (dp_valid_q && HREADY) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = dp_write_q ? 32'h0 : HRDATA;
            rsp_err_d   = resp_err_in;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ap_valid_q  <= 1'b0;
            ap_addr_q   <= 32'h0;
            ap_write_q  <= 1'b0;
            ap_size_q   <= 3'b000;
            ap_wdata_q  <= 32'h0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            hwdata_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            ap_valid_q  <= ap_valid_d;
            ap_addr_q   <= ap_addr_d;
            ap_write_q  <= ap_write_d;
            ap_size_q   <= ap_size_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign HTRANS    = (ap_valid_q && !err_seen) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = ap_addr_q;
    assign HWRITE    = ap_write_q;
    assign HSIZE     = ap_size_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA;
    assign HMASTLOCK = 1'b0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
